// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage: owns the PC, issues fetch requests to instruction
//   memory, tolerates multi-cycle memory latency, accepts branch/jump
//   redirects (remembering a redirect that arrives while a fetch is still
//   outstanding), and loads the IF/ID pipeline register.
//
// Ports
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous active-low reset
//   pckeep         in   1   hold PC (load-use stall); also masks redirects
//   control_if_id  in   2   00 advance, 01 flush, 10/11 keep
//   dobranch       in   1   taken branch resolved this cycle
//   branch_target  in  32   branch destination (wins over jump)
//   dojump         in   1   jump resolved this cycle
//   jump_target    in  32   jump destination
//   imem_req       out  1   fetch request valid
//   imem_addr      out 32   fetch address (the PC)
//   imem_ready     in   1   imem_rdata valid for imem_addr this cycle
//   imem_rdata     in  32   fetched instruction
//   if_id_pc       out 32   PC of the instruction in IF/ID
//   if_id_pc4      out 32   that PC plus 4
//   if_id_instr    out 32   instruction in IF/ID (0 when invalid)
//   if_id_valid    out  1   IF/ID holds a real instruction
//   wait_cycles    out 16   saturating count of request cycles without ready
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pckeep,
    input  logic [1:0]  control_if_id,
    input  logic        dobranch,
    input  logic [31:0] branch_target,
    input  logic        dojump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [15:0] wait_cycles
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc4;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic [15:0] r_wait_cycles;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_accept;

    // Redirect selection: a stall masks redirects (upstream re-asserts them),
    // and a branch takes priority over a simultaneous jump.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = 32'h0000_0000;
        w_pc_plus4 = r_pc + 32'h0000_0004;
        // A response is usable only if no redirect is still pending for it.
        w_accept   = r_req & imem_ready & ~r_pend_valid;
        if (!pckeep) begin
            w_redirect = dobranch | dojump;
        end else begin
            w_redirect = 1'b0;
        end
        if (dobranch) begin
            w_target = branch_target;
        end else begin
            w_target = jump_target;
        end
    end

    // Fetch state machine, PC and pending-redirect bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= BOOT;
            r_req         <= 1'b0;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0000_0000;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH, WAIT: begin
                    r_req <= 1'b1;
                    if (!imem_ready) begin
                        // Address must stay put while memory is busy; a
                        // redirect is parked until the response arrives.
                        r_state <= WAIT;
                        if (w_redirect) begin
                            r_pend_valid  <= 1'b1;
                            r_pend_target <= w_target;
                        end
                    end else begin
                        r_state <= FETCH;
                        if (pckeep) begin
                            r_pc <= r_pc;
                        end else if (w_redirect) begin
                            r_pc         <= w_target;
                            r_pend_valid <= 1'b0;
                        end else if (r_pend_valid) begin
                            r_pc         <= r_pend_target;
                            r_pend_valid <= 1'b0;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                default: begin
                    r_state <= BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_pc4   <= 32'h0000_0000;
            r_if_id_instr <= 32'h0000_0000;
            r_if_id_valid <= 1'b0;
        end else begin
            case (control_if_id)
                2'b00: begin
                    if (w_accept) begin
                        r_if_id_pc    <= r_pc;
                        r_if_id_pc4   <= w_pc_plus4;
                        r_if_id_instr <= imem_rdata;
                        r_if_id_valid <= 1'b1;
                    end else begin
                        r_if_id_instr <= 32'h0000_0000;
                        r_if_id_valid <= 1'b0;
                    end
                end
                2'b01: begin
                    r_if_id_instr <= 32'h0000_0000;
                    r_if_id_valid <= 1'b0;
                end
                default: begin
                    r_if_id_valid <= r_if_id_valid;
                end
            endcase
        end
    end

    // Saturating memory-stall counter; cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cycles <= 16'h0000;
        end else if (r_req && !imem_ready && (r_wait_cycles != 16'hFFFF)) begin
            r_wait_cycles <= r_wait_cycles + 16'h0001;
        end else begin
            r_wait_cycles <= r_wait_cycles;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign wait_cycles = r_wait_cycles;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        pckeep;
    logic [1:0]  control_if_id;
    logic        dobranch;
    logic [31:0] branch_target;
    logic        dojump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [15:0] wait_cycles;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .pckeep(pckeep), .control_if_id(control_if_id),
        .dobranch(dobranch), .branch_target(branch_target),
        .dojump(dojump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .wait_cycles(wait_cycles)
    );

    // Instruction memory model: word at address A reads as 0xC0DE0000 | A.
    assign imem_rdata = 32'hC0DE_0000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; pckeep = 1'b0; control_if_id = 2'b00;
        dobranch = 1'b0; branch_target = 32'h0; dojump = 1'b0; jump_target = 32'h0;
        imem_ready = 1'b1;
        step(); step();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0000_0000);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4",   if_id_pc4, 32'h0);
        chk("rst_wait",  {16'd0, wait_cycles}, 32'd0);

        // Boot
        reset = 1'b1;
        chk("boot_req0", {31'd0, imem_req}, 32'd0);
        step();
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr0", imem_addr, 32'h0);
        chk("boot_valid0", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("addr4", imem_addr, 32'h4);
        chk("ifid_valid_first", {31'd0, if_id_valid}, 32'd1);
        chk("ifid_pc_first", if_id_pc, 32'h0);
        chk("ifid_pc4_first", if_id_pc4, 32'h4);
        chk("ifid_instr_first", if_id_instr, 32'hC0DE_0000);
        step();
        chk("addr8", imem_addr, 32'h8);
        chk("ifid_pc_4", if_id_pc, 32'h4);

        // Memory wait: three cycles without ready at address 8
        imem_ready = 1'b0;
        step();
        chk("wait1_addr", imem_addr, 32'h8);
        chk("wait1_valid", {31'd0, if_id_valid}, 32'd0);
        chk("wait1_instr", if_id_instr, 32'h0);
        step();
        chk("wait2_addr", imem_addr, 32'h8);
        step();
        chk("wait3_addr", imem_addr, 32'h8);
        chk("wait3_valid", {31'd0, if_id_valid}, 32'd0);
        chk("wait3_cnt", {16'd0, wait_cycles}, 32'd3);
        imem_ready = 1'b1;
        step();
        chk("after_wait_instr", if_id_instr, 32'hC0DE_0008);
        chk("after_wait_pc", if_id_pc, 32'h8);
        chk("after_wait_addr", imem_addr, 32'hC);
        chk("after_wait_cnt", {16'd0, wait_cycles}, 32'd3);

        // Redirect during wait at 0x10
        step();
        chk("addr10", imem_addr, 32'h10);
        imem_ready = 1'b0;
        step();
        chk("w10_addr", imem_addr, 32'h10);
        dobranch = 1'b1; branch_target = 32'h0000_0100;
        step();
        chk("w10_redirect_addr", imem_addr, 32'h10);
        chk("w10_cnt", {16'd0, wait_cycles}, 32'd5);
        dobranch = 1'b0; imem_ready = 1'b1;
        step();
        chk("discard_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        step();
        chk("redir_instr", if_id_instr, 32'hC0DE_0100);
        chk("redir_valid", {31'd0, if_id_valid}, 32'd1);
        chk("addr104", imem_addr, 32'h104);

        // Load-use stall with an ignored branch, then flush with redirect
        pckeep = 1'b1; control_if_id = 2'b10; dobranch = 1'b1; branch_target = 32'h0000_0200;
        step();
        chk("stall_addr", imem_addr, 32'h104);
        chk("stall_pc", if_id_pc, 32'h100);
        chk("stall_instr", if_id_instr, 32'hC0DE_0100);
        chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
        pckeep = 1'b0; control_if_id = 2'b01;
        step();
        chk("flush_addr", imem_addr, 32'h200);
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("flush_instr", if_id_instr, 32'h0);
        chk("flush_pc_hold", if_id_pc, 32'h100);

        // Wrap-around
        dobranch = 1'b0; control_if_id = 2'b00; dojump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        chk("jump_addr", imem_addr, 32'hFFFF_FFFC);
        chk("jump_ifid_pc", if_id_pc, 32'h200);
        dojump = 1'b0;
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_ifid_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_instr", if_id_instr, 32'hFFFF_FFFC);

        // Branch beats jump
        dobranch = 1'b1; branch_target = 32'h300; dojump = 1'b1; jump_target = 32'h400;
        step();
        chk("prio_addr", imem_addr, 32'h300);
        dobranch = 1'b0; dojump = 1'b0;
        step();
        chk("addr304", imem_addr, 32'h304);

        // Reset asserted mid-wait with a pending redirect
        imem_ready = 1'b0;
        step();
        dojump = 1'b1; jump_target = 32'h500;
        step();
        chk("pre_rst_cnt", {16'd0, wait_cycles}, 32'd7);
        #2 reset = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_pc", if_id_pc, 32'h0);
        chk("async_cnt", {16'd0, wait_cycles}, 32'd0);
        reset = 1'b1; dojump = 1'b0; imem_ready = 1'b1;
        chk("post_rst_req0", {31'd0, imem_req}, 32'd0);
        step();
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req1", {31'd0, imem_req}, 32'd1);
        step();
        chk("post_rst_next", imem_addr, 32'h4);
        chk("post_rst_valid", {31'd0, if_id_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- pckeep  in  1  hold PC (load-use stall).
- control_if_id  in  2  IF/ID control: 00 go on, 01 flush, 10 keep, 11 treated as keep.
- dobranch  in  1  taken branch resolved this cycle.
- branch_target  in  32  branch destination.
- dojump  in  1  j/jal/jr resolved this cycle.
- jump_target  in  32  jump destination.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (equals PC).
- imem_ready  in  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  in  32  fetched instruction.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_pc4  out  32  that PC plus 4.
- if_id_instr  out  32  instruction held in IF/ID; 0 (nop) when invalid.
- if_id_valid  out  1  IF/ID holds a real instruction.
- wait_cycles  out  16  count of request cycles without ready.

Function
REQ-003 SHALL implement states BOOT, FETCH, WAIT; BOOT -> FETCH unconditionally after one cycle.
REQ-004 SHALL drive imem_req=0 in BOOT and imem_req=1 in FETCH and WAIT, with imem_addr=PC at all times.
REQ-005 SHALL keep imem_addr stable while in WAIT, regardless of pckeep, dobranch or dojump.
REQ-006 SHALL move from FETCH or WAIT to WAIT on a request cycle with imem_ready=0, and to FETCH on a request cycle with imem_ready=1.
REQ-007 SHALL define a redirect as (dobranch|dojump) with pckeep=0; branch_target wins over jump_target when both are asserted.
REQ-008 SHALL ignore dobranch and dojump whenever pckeep=1; they are re-asserted upstream.
REQ-009 SHALL, on a request cycle with imem_ready=0 and a redirect, set pend_valid=1 and pend_target=the selected target; a later redirect overwrites the pending target.
REQ-010 SHALL, on a request cycle with imem_ready=1, update the PC by the first matching rule:
- pckeep=1: PC holds and pending state is unchanged.
- redirect now: PC=target and pend_valid cleared.
- pend_valid=1: PC=pend_target and pend_valid cleared.
- otherwise: PC=PC+4, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-011 SHALL hold the PC on any request cycle with imem_ready=0.
REQ-012 SHALL update IF/ID on every edge per control_if_id:
- 01: instr=0, valid=0, pc and pc4 unchanged.
- 10/11: all IF/ID fields hold.
- 00 with imem_ready=1, pend_valid=0, in FETCH/WAIT: pc=PC, pc4=PC+4, instr=imem_rdata, valid=1.
- 00 otherwise (no response, wrong-path response, or BOOT): instr=0, valid=0.
REQ-013 SHALL compute pc4 with the same 32-bit wrap as the PC.
REQ-014 SHALL increment wait_cycles each cycle with imem_req=1 and imem_ready=0, saturating at 16'hFFFF; it never clears except on reset.
REQ-015 SHALL have no combinational path from imem_rdata to any output.

Reset
REQ-016 SHALL, while reset=0 (asynchronous assert), force state=BOOT, PC=RESET_PC, pend_valid=0, pend_target=0, if_id_pc=0, if_id_pc4=0, if_id_instr=0, if_id_valid=0 and wait_cycles=0.
REQ-017 SHALL drive imem_req=0 during reset.
REQ-018 SHALL treat reset asserted mid-WAIT as discarding any pending redirect and outstanding request; the first request after release is to RESET_PC.

Verification
REQ-019 Boot: release reset, imem_ready=1, control 00 -> cycle 1 imem_req=0; then addrs 0,4,8; if_id_valid=1 from the first FETCH edge with if_id_pc=0 and if_id_pc4=4.
REQ-020 Memory wait: imem_ready=0 for 3 cycles at addr 8 -> addr stays 8, if_id_valid=0 for those cycles, wait_cycles=3, then instr@8 loads.
REQ-021 Redirect during wait: in WAIT at addr 0x10, dobranch=1 with branch_target=0x100 for one cycle, then ready=1 -> addr stays 0x10 until ready, response discarded (valid=0), next addr 0x100.
REQ-022 Load-use: pckeep=1, control 10, dobranch=1, ready=1 -> PC and IF/ID unchanged, branch ignored; next cycle pckeep=0 with dobranch=1 and control 01 -> PC=target, if_id_valid=0.
REQ-023 Wrap and priority: PC=0xFFFF_FFFC, ready=1 -> next PC 0 and if_id_pc4=0; dobranch and dojump together -> PC=branch_target.
REQ-024 Reset mid-wait: pend_valid=1, assert reset asynchronously -> outputs zero immediately, imem_req=0, first post-reset request to RESET_PC.
